// File: rtl/sram_rr_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port SRAM with registered read data.
// One operation in flight at a time: accept (IDLE), drive SRAM (ISSUE), collect data (WAIT).
module sram_rr_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [WORD_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [WORD_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [WORD_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [WORD_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0] sram_din,
  output logic                  sram_we,
  input  logic [WORD_WIDTH-1:0] sram_dout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e                state_q;
  logic                  last_grant_q;
  logic                  owner_q;
  logic                  op_rd_q;

  logic                  grant0_s;
  logic                  grant1_s;
  logic                  hs0_s;
  logic                  hs1_s;
  logic                  sel_wr_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [WORD_WIDTH-1:0] sel_wdata_s;

  // Grant: a lone requester wins; on contention the port that did not win last time goes.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0_s = last_grant_q;
      grant1_s = ~last_grant_q;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  assign req0_ready = (state_q == ST_IDLE) & grant0_s;
  assign req1_ready = (state_q == ST_IDLE) & grant1_s;
  assign hs0_s      = req0_valid & req0_ready;
  assign hs1_s      = req1_valid & req1_ready;

  // Command mux: at most one handshake per cycle, so port 1 is picked only when it shook hands.
  always_comb begin
    if (hs1_s) begin
      sel_wr_s    = req1_wr;
      sel_addr_s  = req1_addr;
      sel_wdata_s = req1_wdata;
    end else begin
      sel_wr_s    = req0_wr;
      sel_addr_s  = req0_addr;
      sel_wdata_s = req0_wdata;
    end
  end

  // Sequencer FSM with all SRAM-facing and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_rd_q      <= 1'b0;
      sram_addr    <= '0;
      sram_din     <= '0;
      sram_we      <= 1'b1;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp1_rdata   <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hs0_s || hs1_s) begin
            sram_addr    <= sel_addr_s;
            sram_din     <= sel_wdata_s;
            sram_we      <= ~sel_wr_s;
            owner_q      <= hs1_s;
            last_grant_q <= hs1_s;
            op_rd_q      <= ~sel_wr_s;
            state_q      <= ST_ISSUE;
          end else begin
            sram_we <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          sram_we <= 1'b1;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          sram_we <= 1'b1;
          // Read data was registered by the SRAM at the previous edge and is stable now.
          if (owner_q) begin
            rsp1_valid <= 1'b1;
            if (op_rd_q) begin
              rsp1_rdata <= sram_dout;
            end else begin
              rsp1_rdata <= rsp1_rdata;
            end
          end else begin
            rsp0_valid <= 1'b1;
            if (op_rd_q) begin
              rsp0_rdata <= sram_dout;
            end else begin
              rsp0_rdata <= rsp0_rdata;
            end
          end
          state_q <= ST_IDLE;
        end
        default: begin
          sram_we <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Randomized self-checking bench: a transaction-level model predicts readies, SRAM strobes and
// responses cycle by cycle from the arbitration and timing rules; an SRAM model sits on the bus.
module tb_sram_rr_arbiter;
  localparam int AW = 4;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req0_ready, req0_wr;
  logic [AW-1:0] req0_addr;
  logic [WW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [WW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_wr;
  logic [AW-1:0] req1_addr;
  logic [WW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [WW-1:0] rsp1_rdata;
  logic [AW-1:0] sram_addr;
  logic [WW-1:0] sram_din;
  logic          sram_we;
  logic [WW-1:0] sram_dout;

  always #5 clk = ~clk;

  sram_rr_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we), .sram_dout(sram_dout)
  );

  // SRAM: synchronous write on we=0, registered read data.
  logic [WW-1:0] sram_mem [16];
  initial begin
    for (int i = 0; i < 16; i++) sram_mem[i] = '0;
    sram_dout = '0;
  end
  always @(posedge clk) begin
    if (!sram_we) sram_mem[sram_addr] <= sram_din;
    sram_dout <= sram_mem[sram_addr];
  end

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } cmd_t;

  cmd_t q0[$];
  cmd_t q1[$];
  bit   pres0, pres1, always_mode;

  // Reference model: cyc is the index of the next rising edge.
  int            cyc, free_e, issue_cyc, rsp_cyc, rsp_port;
  bit            last, issue_wr, rsp_rd;
  logic [AW-1:0] issue_addr;
  logic [WW-1:0] issue_data, rsp_val, undo_val;
  logic [WW-1:0] exp_rd0, exp_rd1;
  logic [WW-1:0] mmem [16];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic accept(input int p);
    cmd_t c;
    if (p == 0) begin c = q0.pop_front(); pres0 = 0; end
    else        begin c = q1.pop_front(); pres1 = 0; end
    last       = (p == 1);
    free_e     = cyc + 3;
    issue_cyc  = cyc + 1;
    issue_wr   = c.wr;
    issue_addr = c.addr;
    issue_data = c.data;
    rsp_cyc    = cyc + 3;
    rsp_port   = p;
    rsp_rd     = !c.wr;
    undo_val   = mmem[c.addr];
    if (c.wr) mmem[c.addr] = c.data;
    else      rsp_val = mmem[c.addr];
  endtask

  task automatic run_cycle();
    logic [31:0] r;
    bit idle, eg0, eg1;
    if (!pres0 && q0.size() > 0 && (always_mode || $urandom_range(0, 2) != 0)) pres0 = 1;
    if (!pres1 && q1.size() > 0 && (always_mode || $urandom_range(0, 2) != 0)) pres1 = 1;
    r = $urandom;
    if (pres0) begin
      req0_valid = 1'b1; req0_wr = q0[0].wr; req0_addr = q0[0].addr; req0_wdata = q0[0].data;
    end else begin
      req0_valid = 1'b0; req0_wr = r[0]; req0_addr = r[4:1]; req0_wdata = r[12:5];
    end
    if (pres1) begin
      req1_valid = 1'b1; req1_wr = q1[0].wr; req1_addr = q1[0].addr; req1_wdata = q1[0].data;
    end else begin
      req1_valid = 1'b0; req1_wr = r[13]; req1_addr = r[17:14]; req1_wdata = r[25:18];
    end
    @(negedge clk);
    idle = (cyc >= free_e);
    eg0 = 0;
    eg1 = 0;
    if (idle) begin
      if (pres0 && pres1) begin eg0 = last; eg1 = !last; end
      else begin eg0 = pres0; eg1 = pres1; end
    end
    chk("req0_ready", 32'(req0_ready), 32'(eg0));
    chk("req1_ready", 32'(req1_ready), 32'(eg1));
    if (rsp_cyc == cyc && rsp_rd) begin
      if (rsp_port == 0) exp_rd0 = rsp_val;
      else               exp_rd1 = rsp_val;
    end
    chk("rsp0_valid", 32'(rsp0_valid), 32'(rsp_cyc == cyc && rsp_port == 0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(rsp_cyc == cyc && rsp_port == 1));
    chk("rsp0_rdata", 32'(rsp0_rdata), 32'(exp_rd0));
    chk("rsp1_rdata", 32'(rsp1_rdata), 32'(exp_rd1));
    chk("sram_we", 32'(sram_we), 32'(!(issue_cyc == cyc && issue_wr)));
    if (issue_cyc == cyc) begin
      chk("sram_addr", 32'(sram_addr), 32'(issue_addr));
      chk("sram_din", 32'(sram_din), 32'(issue_data));
    end
    @(posedge clk);
    if (eg0) accept(0);
    else if (eg1) accept(1);
    cyc++;
    #1;
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cyc <= rsp_cyc) && n < budget) begin
      run_cycle();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 32'(n), 32'(0));
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks the asynchronous response.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sram_we", 32'(sram_we), 32'd1);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_din", 32'(sram_din), 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp0_rdata", 32'(rsp0_rdata), 32'd0);
    chk("rst_rsp1_rdata", 32'(rsp1_rdata), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    pres0 = 0;
    pres1 = 0;
    // A write still waiting for its SRAM edge never lands.
    if (issue_wr && cyc <= issue_cyc) mmem[issue_addr] = undo_val;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_we", 32'(sram_we), 32'd1);
    chk("rst_hold_rsp0", 32'(rsp0_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    free_e = cyc; issue_cyc = -1; rsp_cyc = -1; issue_wr = 0; rsp_rd = 0;
    last = 1; exp_rd0 = '0; exp_rd1 = '0;
  endtask

  function automatic cmd_t mk(input bit wr, input int addr, input int data);
    cmd_t c;
    c.wr   = wr;
    c.addr = AW'(addr);
    c.data = WW'(data);
    return c;
  endfunction

  initial begin
    int n;
    logic [31:0] r;
    req0_valid = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0;
    for (int i = 0; i < 16; i++) mmem[i] = '0;
    cyc = 0; free_e = 0; issue_cyc = -1; rsp_cyc = -1; rsp_port = 0;
    issue_wr = 0; rsp_rd = 0; last = 1; always_mode = 1;
    @(posedge clk);
    #1;
    do_reset();

    // Port 0 writes 0xA5 to addr 3 while port 1 reads addr 3.
    q0.push_back(mk(1, 3, 8'hA5));
    q1.push_back(mk(0, 3, 0));
    run_drain(20);

    // Both ports saturated: grants alternate.
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      q0.push_back(mk(r[0], int'(r[4:1]), int'(r[12:5])));
      q1.push_back(mk(r[13], int'(r[17:14]), int'(r[25:18])));
    end
    run_drain(60);

    // Port 1 alone.
    for (int i = 0; i < 4; i++) q1.push_back(mk(0, i * 5, 0));
    run_drain(30);

    // Fill every address through port 0, then read all back through port 1.
    for (int a = 0; a < 16; a++) q0.push_back(mk(1, a, a ^ 8'h5A));
    run_drain(80);
    for (int a = 0; a < 16; a++) q1.push_back(mk(0, (a + 15) % 16, 0));
    run_drain(80);

    // Random traffic with random valid gaps.
    always_mode = 0;
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      q0.push_back(mk(r[0], int'(r[4:1]), int'(r[12:5])));
      r = $urandom;
      q1.push_back(mk(r[0], int'(r[4:1]), int'(r[12:5])));
    end
    run_drain(600);
    always_mode = 1;

    // Reset during the ISSUE cycle of a write: strobe drops at once, write is lost.
    q0.push_back(mk(1, 7, 8'h3C));
    n = 0;
    while (!(cyc == issue_cyc && issue_wr) && n < 10) begin run_cycle(); n++; end
    chk("reach_issue", 32'(cyc == issue_cyc && issue_wr), 32'd1);
    chk("issue_we_low", 32'(sram_we), 32'd0);
    do_reset();
    q1.push_back(mk(0, 7, 0));
    run_drain(20);

    // Reset during WAIT of a read: no response, and port 0 wins the first contest after.
    q1.push_back(mk(0, 3, 0));
    n = 0;
    while (!(rsp_cyc >= 0 && cyc == rsp_cyc - 1) && n < 10) begin run_cycle(); n++; end
    chk("reach_wait", 32'(rsp_cyc >= 0 && cyc == rsp_cyc - 1), 32'd1);
    do_reset();
    q0.push_back(mk(1, 9, 8'h11));
    q1.push_back(mk(1, 9, 8'h22));
    q0.push_back(mk(0, 9, 0));
    run_drain(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", n_checks, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
Two-port round-robin arbiter and sequencer in front of the single-port sram_16x8. It accepts read/write requests from two requesters over valid/ready, drives the SRAM's addr/din/we (we active-low = write), captures the registered read data and returns a one-cycle response per request. Only one SRAM operation is in flight at a time.

Parameters:
ADDR_WIDTH, 4, SRAM address width
WORD_WIDTH, 8, SRAM data width

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 command valid
req0_ready  output  1  requester 0 command accepted this cycle
req0_wr  input  1  1 = write, 0 = read
req0_addr  input  ADDR_WIDTH  requester 0 address
req0_wdata  input  WORD_WIDTH  requester 0 write data
rsp0_valid  output  1  one-cycle completion pulse for requester 0
rsp0_rdata  output  WORD_WIDTH  read data (valid with rsp0_valid on reads)
req1_valid, req1_ready, req1_wr, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata  same as port 0, for requester 1
sram_addr  output  ADDR_WIDTH  to SRAM addr
sram_din  output  WORD_WIDTH  to SRAM din
sram_we  output  1  to SRAM we; 0 = write, 1 = read
sram_dout  input  WORD_WIDTH  from SRAM dout

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sram_we=1, sram_addr=0, sram_din=0, rsp0/1_valid=0, rsp0/1_rdata=0, last_grant=1 (port 0 wins first contest).
- sram_we is 1 at all times except the single ISSUE cycle of a write; it must never be 0 in IDLE, WAIT or reset.
- FSM: IDLE -> ISSUE -> WAIT -> IDLE; the IDLE->ISSUE transition happens on any handshake.
- IDLE: grant is computed combinationally from the valids; reqN_ready = (state==IDLE) & grantN. At most one ready high. If only one valid, that port is granted. If both, grant the port != last_grant. Readies may depend on valids.
- Handshake at edge E0 (valid & ready): register sram_addr<=addr, sram_din<=wdata, sram_we<=~wr; latch owner and op type; last_grant<=owner; state ISSUE.
- ISSUE (cycle after E0): SRAM samples at E1. At E1: sram_we<=1, state WAIT.
- WAIT: at E2, if op was read, rspN_rdata<=sram_dout (SRAM registered output, updated at E1). rspN_valid<=1 for owner only; state IDLE.
- rspN_valid is high exactly one cycle (after E2); no backpressure on responses. rspN_rdata holds its value until the next read by that port; writes leave it unchanged.
- Latency: accept to rsp_valid = 3 edges; max throughput one op per 3 cycles (next accept at E3 is legal while rsp_valid is high).
- Requests are not stored unless accepted; a requester holds valid and fields until ready.
- sram_addr/sram_din hold last values after the op; don't-care to SRAM since we=1.
- Reset mid-operation: an in-flight op is dropped, no rsp pulse, sram_we returns to 1 immediately (async).
- Back-to-back same address write then read (either port) returns the new data (ops are fully serialised).

Test Plan:
- Reset: rst_n=0 mid-sim -> all outputs at reset values, sram_we=1 immediately without a clock edge.
- Port0 write addr 3 data 0xA5, then port1 read addr 3 -> sram_we=0 for exactly one cycle; rsp1_valid pulse 3 edges after accept with rsp1_rdata=0xA5; rsp0_valid pulsed for the write.
- Both valid continuously after reset -> grants alternate 0,1,0,1; each port gets one completion per 6 cycles.
- Only port1 valid for 4 ops -> port1 is granted every 3 cycles; no idle cycles wasted on port0.
- Fill addr 0..15 with addr^0x5A via port 0, read back all via port 1 -> all match, including wrap addr 15 -> 0 sequence.
- Assert rst_n=0 during WAIT of a read -> no rsp pulse; after release first grant goes to port 0.
